// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-allocate data cache in front of a
// word-addressed backing memory that takes MEM_LATENCY cycles per access.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   addr           word address (only the low log2(MEM_WORDS) bits are used)
//   write_data     data stored on a write request
//   memwrite       1 = write request, 0 = read request
//   enable         request valid, sampled only while idle
//   read_data      data of the most recently completed read
//   write_finished one-cycle strobe when a write completes
//   read_finished  one-cycle strobe when a read completes
module data_cache #(
    parameter int LINES       = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int MEM_LATENCY = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        enable,
    output logic [31:0] read_data,
    output logic        write_finished,
    output logic        read_finished
);

    localparam int IW = $clog2(LINES);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int TW = AW - IW;
    // clog2(N) bits are enough to hold the load value N-1.
    localparam int CW = $clog2(MEM_LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE_WAIT,
        READ_MISS
    } state_t;

    state_t state;
    logic [CW-1:0] cnt;

    // Request captured at accept time; inputs may change afterwards.
    logic [AW-1:0] req_word;
    logic [31:0]   req_data;

    logic [LINES-1:0] line_valid;
    logic [TW-1:0]    line_tag  [LINES];
    logic [31:0]      line_data [LINES];

    // Backing memory is not touched by reset; it starts out all zero.
    logic [31:0] mem [MEM_WORDS] = '{default: '0};

    logic [AW-1:0] word;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic          hit;
    logic          done;
    logic          line_we;
    logic          mem_we;
    logic [31:0]   fill_data;
    logic          unused_addr;

    assign word    = addr[AW-1:0];
    assign idx     = word[IW-1:0];
    assign tag     = word[AW-1:IW];
    assign req_idx = req_word[IW-1:0];
    assign req_tag = req_word[AW-1:IW];

    assign unused_addr = ^addr[31:AW];

    assign hit  = line_valid[idx] && (line_tag[idx] == tag);
    assign done = (state != IDLE) && (cnt == '0);

    // Gate array updates with reset so an aborted request commits nothing.
    assign line_we   = done && !reset;
    assign mem_we    = line_we && (state == WRITE_WAIT);
    assign fill_data = (state == WRITE_WAIT) ? req_data : mem[req_word];

    always_ff @(posedge clk) begin
        if (line_we) begin
            line_tag[req_idx]  <= req_tag;
            line_data[req_idx] <= fill_data;
        end
        if (mem_we) begin
            mem[req_word] <= req_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            req_word       <= '0;
            req_data       <= '0;
            line_valid     <= '0;
            read_data      <= '0;
            write_finished <= 1'b0;
            read_finished  <= 1'b0;
        end else begin
            write_finished <= 1'b0;
            read_finished  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        req_word <= word;
                        req_data <= write_data;
                        if (memwrite) begin
                            state <= WRITE_WAIT;
                            cnt   <= CNT_LOAD;
                        end else if (hit) begin
                            read_data     <= line_data[idx];
                            read_finished <= 1'b1;
                        end else begin
                            state <= READ_MISS;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                WRITE_WAIT: begin
                    if (cnt == '0) begin
                        line_valid[req_idx] <= 1'b1;
                        write_finished      <= 1'b1;
                        state               <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                READ_MISS: begin
                    if (cnt == '0) begin
                        line_valid[req_idx] <= 1'b1;
                        read_data           <= mem[req_word];
                        read_finished       <= 1'b1;
                        state               <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Testbench for data_cache: directed scenarios plus randomized traffic,
// checked against an address-level model of cache contents and memory.
module tb_data_cache;

    localparam int NL  = 32;
    localparam int MW  = 1024;
    localparam int LAT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        enable;
    logic [31:0] read_data;
    logic        write_finished;
    logic        read_finished;

    int checks = 0;
    int fails  = 0;

    // Reference model: memory contents, which address each line holds,
    // and the value of the last completed read.
    logic [31:0] m_mem [MW];
    bit          m_valid [NL];
    int          m_tag [NL];
    logic [31:0] m_last_rd;

    data_cache #(
        .LINES(NL),
        .MEM_WORDS(MW),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .write_data(write_data),
        .memwrite(memwrite),
        .enable(enable),
        .read_data(read_data),
        .write_finished(write_finished),
        .read_finished(read_finished)
    );

    always #5 clk = ~clk;

    // Expected completion edge (edges after accept) and read_data afterwards.
    task automatic model_req(input bit we, input logic [31:0] a,
                             input logic [31:0] d, output int e_ofs,
                             output logic [31:0] e_rd);
        int w;
        int i;
        int t;
        bit hit;
        w = int'(a % 32'(MW));
        i = w % NL;
        t = w / NL;
        hit = m_valid[i] && (m_tag[i] == t);
        if (we) begin
            m_mem[w] = d;
            e_ofs = LAT;
        end else begin
            e_ofs = hit ? 0 : LAT;
            m_last_rd = m_mem[w];
        end
        e_rd = m_last_rd;
        m_valid[i] = 1'b1;
        m_tag[i] = t;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_last_rd = '0;
    endtask

    // Issue one request for a single cycle, then scramble the inputs and
    // wait (bounded) for a strobe. ofs = edges after accept at which it rose.
    task automatic run_req(input bit we, input logic [31:0] a,
                           input logic [31:0] d, output int ofs,
                           output logic [31:0] rd, output logic wf,
                           output logic rf, output logic extra);
        @(negedge clk);
        enable = 1'b1;
        memwrite = we;
        addr = a;
        write_data = d;
        @(negedge clk);
        enable = 1'b0;
        memwrite = 1'($urandom);
        addr = $urandom;
        write_data = $urandom;
        ofs = 0;
        while (!(read_finished || write_finished) && ofs < 100) begin
            @(negedge clk);
            ofs++;
        end
        rd = read_data;
        wf = write_finished;
        rf = read_finished;
        @(negedge clk);
        extra = read_finished | write_finished;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        memwrite = 1'b0;
        addr = '0;
        write_data = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (read_data !== 32'h0 || write_finished !== 1'b0 ||
                read_finished !== 1'b0) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: rd=%h wf=%b rf=%b, required 0 0 0",
                         c, read_data, write_finished, read_finished);
            end
        end
        model_reset();
    endtask

    task automatic test_write_read();
        int ofs, e_ofs;
        logic [31:0] rd, e_rd;
        logic wf, rf, ex;
        run_req(1'b1, 32'd1, 32'd7, ofs, rd, wf, rf, ex);
        model_req(1'b1, 32'd1, 32'd7, e_ofs, e_rd);
        checks++;
        if (ofs !== e_ofs || wf !== 1'b1 || rf !== 1'b0 || ex !== 1'b0 ||
            rd !== e_rd) begin
            fails++;
            $display("FAIL write_1: ofs=%0d wf=%b rf=%b next=%b rd=%h, required %0d 1 0 0 %h",
                     ofs, wf, rf, ex, rd, e_ofs, e_rd);
        end
        run_req(1'b0, 32'd1, 32'd0, ofs, rd, wf, rf, ex);
        model_req(1'b0, 32'd1, 32'd0, e_ofs, e_rd);
        checks++;
        if (ofs !== e_ofs || rf !== 1'b1 || wf !== 1'b0 || ex !== 1'b0 ||
            rd !== e_rd) begin
            fails++;
            $display("FAIL read_1_hit: ofs=%0d rf=%b wf=%b next=%b rd=%h, required %0d 1 0 0 %h",
                     ofs, rf, wf, ex, rd, e_ofs, e_rd);
        end
    endtask

    task automatic test_write_hold();
        int ofs, e_ofs, nwf, nrf, first;
        logic [31:0] rd, e_rd;
        logic wf, rf, ex;
        nwf = 0;
        nrf = 0;
        first = -1;
        @(negedge clk);
        enable = 1'b1;
        memwrite = 1'b1;
        addr = 32'd32;
        write_data = 32'd3;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (write_finished) begin
                nwf++;
                if (first < 0) first = i;
            end
            if (read_finished) nrf++;
            if (i == 4) enable = 1'b0;
        end
        model_req(1'b1, 32'd32, 32'd3, e_ofs, e_rd);
        checks++;
        if (nwf !== 1 || nrf !== 0 || first !== e_ofs) begin
            fails++;
            $display("FAIL write_hold: pulses=%0d rpulses=%0d at=%0d, required 1 0 %0d",
                     nwf, nrf, first, e_ofs);
        end
        run_req(1'b0, 32'd1, 32'd0, ofs, rd, wf, rf, ex);
        model_req(1'b0, 32'd1, 32'd0, e_ofs, e_rd);
        checks++;
        if (ofs !== e_ofs || rf !== 1'b1 || rd !== e_rd) begin
            fails++;
            $display("FAIL hold_read_1: ofs=%0d rf=%b rd=%h, required %0d 1 %h",
                     ofs, rf, rd, e_ofs, e_rd);
        end
        run_req(1'b0, 32'd32, 32'd0, ofs, rd, wf, rf, ex);
        model_req(1'b0, 32'd32, 32'd0, e_ofs, e_rd);
        checks++;
        if (ofs !== e_ofs || rf !== 1'b1 || rd !== e_rd) begin
            fails++;
            $display("FAIL hold_read_32: ofs=%0d rf=%b rd=%h, required %0d 1 %h",
                     ofs, rf, rd, e_ofs, e_rd);
        end
    endtask

    task automatic test_conflict();
        int ofs, e_ofs;
        logic [31:0] rd, e_rd;
        logic wf, rf, ex;
        logic [31:0] seq_a [3];
        bit seq_w [3];
        seq_a[0] = 32'd0;
        seq_w[0] = 1'b1;
        seq_a[1] = 32'd32;
        seq_w[1] = 1'b0;
        seq_a[2] = 32'd32;
        seq_w[2] = 1'b0;
        for (int s = 0; s < 3; s++) begin
            run_req(seq_w[s], seq_a[s], 32'd9, ofs, rd, wf, rf, ex);
            model_req(seq_w[s], seq_a[s], 32'd9, e_ofs, e_rd);
            checks++;
            if (ofs !== e_ofs || wf !== seq_w[s] || rf !== !seq_w[s] ||
                ex !== 1'b0 || rd !== e_rd) begin
                fails++;
                $display("FAIL conflict_%0d: ofs=%0d wf=%b rf=%b next=%b rd=%h, required %0d %b %b 0 %h",
                         s, ofs, wf, rf, ex, rd, e_ofs, seq_w[s], !seq_w[s], e_rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ofs, e_ofs;
        logic [31:0] rd, e_rd;
        logic wf, rf, ex;
        logic [31:0] seq [10];
        logic [31:0] exp_rd [10];
        int dummy;
        run_req(1'b0, 32'd5, 32'd0, ofs, rd, wf, rf, ex);
        model_req(1'b0, 32'd5, 32'd0, e_ofs, e_rd);
        checks++;
        if (ofs !== e_ofs || rf !== 1'b1 || rd !== e_rd) begin
            fails++;
            $display("FAIL cold_read_5: ofs=%0d rf=%b rd=%h, required %0d 1 %h",
                     ofs, rf, rd, e_ofs, e_rd);
        end
        for (int i = 0; i < 10; i++) begin
            seq[i] = (i % 3 == 0) ? 32'd5 : ((i % 3 == 1) ? 32'd1 : 32'd32);
            model_req(1'b0, seq[i], 32'd0, dummy, exp_rd[i]);
        end
        @(negedge clk);
        enable = 1'b1;
        memwrite = 1'b0;
        addr = seq[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (read_finished !== 1'b1 || write_finished !== 1'b0 ||
                read_data !== exp_rd[i]) begin
                fails++;
                $display("FAIL b2b_%0d: rf=%b wf=%b rd=%h, required 1 0 %h",
                         i, read_finished, write_finished, read_data, exp_rd[i]);
            end
            if (i < 9) addr = seq[i + 1];
            else enable = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (read_finished !== 1'b0) begin
            fails++;
            $display("FAIL b2b_stop: rf=%b, required 0", read_finished);
        end
    endtask

    task automatic test_reset_abort();
        int ofs, e_ofs;
        logic [31:0] rd, e_rd;
        logic wf, rf, ex;
        // Reset while a hit strobe is high.
        @(negedge clk);
        enable = 1'b1;
        memwrite = 1'b0;
        addr = 32'd1;
        @(negedge clk);
        enable = 1'b0;
        model_req(1'b0, 32'd1, 32'd0, e_ofs, e_rd);
        checks++;
        if (read_finished !== 1'b1 || read_data !== e_rd) begin
            fails++;
            $display("FAIL pre_reset_hit: rf=%b rd=%h, required 1 %h",
                     read_finished, read_data, e_rd);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (read_finished !== 1'b0 || write_finished !== 1'b0 ||
            read_data !== m_last_rd) begin
            fails++;
            $display("FAIL async_reset: rf=%b wf=%b rd=%h, required 0 0 %h",
                     read_finished, write_finished, read_data, m_last_rd);
        end
        @(negedge clk);
        reset = 1'b0;
        // Reset in the middle of a write to addr 2.
        @(negedge clk);
        enable = 1'b1;
        memwrite = 1'b1;
        addr = 32'd2;
        write_data = 32'd4;
        @(negedge clk);
        enable = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (read_finished !== 1'b0 || write_finished !== 1'b0) begin
            fails++;
            $display("FAIL abort_strobes: rf=%b wf=%b, required 0 0",
                     read_finished, write_finished);
        end
        @(negedge clk);
        reset = 1'b0;
        run_req(1'b0, 32'd2, 32'd0, ofs, rd, wf, rf, ex);
        model_req(1'b0, 32'd2, 32'd0, e_ofs, e_rd);
        checks++;
        if (ofs !== e_ofs || rf !== 1'b1 || rd !== e_rd) begin
            fails++;
            $display("FAIL abort_read_2: ofs=%0d rf=%b rd=%h, required %0d 1 %h",
                     ofs, rf, rd, e_ofs, e_rd);
        end
        run_req(1'b0, 32'd1, 32'd0, ofs, rd, wf, rf, ex);
        model_req(1'b0, 32'd1, 32'd0, e_ofs, e_rd);
        checks++;
        if (ofs !== e_ofs || rf !== 1'b1 || rd !== e_rd) begin
            fails++;
            $display("FAIL after_reset_read_1: ofs=%0d rf=%b rd=%h, required %0d 1 %h",
                     ofs, rf, rd, e_ofs, e_rd);
        end
    endtask

    task automatic test_random();
        int ofs, e_ofs;
        logic [31:0] rd, e_rd, a, d;
        logic wf, rf, ex;
        bit we;
        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            a = ($urandom & 32'hFFFF_FC00) |
                32'($urandom_range(0, 3) * NL + $urandom_range(0, 3));
            d = $urandom;
            run_req(we, a, d, ofs, rd, wf, rf, ex);
            model_req(we, a, d, e_ofs, e_rd);
            checks++;
            if (ofs !== e_ofs || wf !== we || rf !== !we || ex !== 1'b0 ||
                rd !== e_rd) begin
                fails++;
                $display("FAIL random_%0d we=%b a=%h: ofs=%0d wf=%b rf=%b next=%b rd=%h, required %0d %b %b 0 %h",
                         n, we, a, ofs, wf, rf, ex, rd, e_ofs, we, !we, e_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < MW; i++) m_mem[i] = '0;
        m_last_rd = '0;
        test_reset();
        test_write_read();
        test_write_hold();
        test_conflict();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, write-allocate data cache with an internal word-addressed backing memory that has a fixed multi-cycle access latency.
- Serves one word request (read or write) at a time from the processor datapath.
- Completion of each request is signalled by a one-cycle finished strobe.

Parameters:
- LINES, 32, number of cache lines (one 32-bit word per line; power of two).
- MEM_WORDS, 1024, backing-memory depth in 32-bit words (power of two).
- MEM_LATENCY, 20, cycles for a backing-memory access (minimum 2).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- addr  input  32  word address. Only addr[log2(MEM_WORDS)-1:0] is used:
  - index = addr[log2(LINES)-1:0]
  - tag = remaining used bits above the index
  - upper bits are ignored.
- write_data  input  32  data to store on a write.
- memwrite  input  1  1 = write request, 0 = read request.
- enable  input  1  request valid, sampled on rising edge.
- read_data  output  32  data returned by the most recent completed read.
- write_finished  output  1  one-cycle strobe: write complete.
- read_finished  output  1  one-cycle strobe: read complete.

Behaviour:
- Reset (async):
  - state = IDLE; all valid bits = 0; counter = 0.
  - read_data = 0, write_finished = 0, read_finished = 0.
  - Any in-flight request is aborted with no memory or line update.
  - Backing memory contents are not affected by reset and are zero-initialised at time 0.
- States: IDLE, WRITE_WAIT, READ_MISS.
- Accept rule:
  - A request is accepted only at an edge E0 where state = IDLE and enable = 1.
  - addr, write_data and memwrite are captured at E0 and may change afterwards.
  - enable is ignored while state is not IDLE.
- Strobes: write_finished and read_finished default to 0 on every edge unless set as described below.
- Read hit (valid[index] and tag match) at E0:
  - read_data <= line data; read_finished = 1 for the cycle after E0.
  - State stays IDLE.
  - If enable is held high, a new read is accepted every cycle and read_finished stays high.
- Read miss at E0:
  - state -> READ_MISS; counter loaded with MEM_LATENCY-1.
  - At edge E0+MEM_LATENCY: line filled (valid = 1, tag, data = mem[word]); read_data <= mem[word]; read_finished pulses for one cycle; state -> IDLE.
- Write (hit or miss) at E0:
  - state -> WRITE_WAIT; counter loaded with MEM_LATENCY-1.
  - At edge E0+MEM_LATENCY: mem[word] <= write_data, and the line is written (valid = 1, tag, data). This is write-allocate and overwrites any conflicting line. write_finished pulses for one cycle; state -> IDLE.
- Next accept is possible at E0+MEM_LATENCY+1.
- read_data:
  - Changes only on read completion.
  - Holds its value through writes and idle cycles.
- Conflict: addresses with the same index and a different tag evict each other; no stall beyond normal miss latency.
- Counter decrements by 1 per cycle in the wait states and transitions when it reaches 0; it is never allowed to wrap.
- The two finished strobes are never high in the same cycle.

Test Plan:
- Reset then idle 5 cycles with enable = 0 -> read_data = 0, both strobes 0, no state change.
- Write addr = 1, data = 7, enable for 1 cycle -> write_finished high for exactly 1 cycle, MEM_LATENCY cycles after accept. Then read addr = 1 -> read_finished 1 cycle after accept (hit), read_data = 7.
- Write addr = 32, data = 3, with enable held 5 cycles -> only one write is performed, and write_finished pulses once. Then read addr = 1 -> hit, read_data = 7; read addr = 32 -> hit, read_data = 3.
- Conflict check, index 0 (32 and 0 share index 0, tags differ):
  - Write 9 to addr 0 -> line 0 now holds addr 0.
  - Read addr = 32 -> miss: read_finished arrives MEM_LATENCY cycles after accept, read_data = 3.
  - Read addr = 32 again -> hit, 1 cycle.
- Cold read of addr = 5 -> miss latency MEM_LATENCY, read_data = 0. Hold enable high for 10 cycles afterwards -> back-to-back hits, read_finished continuously 1.
- Assert reset mid write to addr = 2 (data = 4) -> strobes drop immediately. A subsequent read of addr = 2 misses and returns 0, proving the aborted write was not committed.
